// File: rtl/pwm_level_decoder.sv
// Fan power PWM receiver: measures high time and period of the synchronised line,
// divides to a duty percentage and classifies it into the fan power level / LED code.
module pwm_level_decoder #(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    parameter int unsigned TH_LOW         = 1,
    parameter int unsigned TH_MID         = 15,
    parameter int unsigned TH_HIGH        = 25
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       pwm_in,
    output logic [6:0] duty_pc,
    output logic [1:0] level,
    output logic [2:0] led_level,
    output logic       valid,
    output logic       busy,
    output logic       stuck
);

    localparam int unsigned      DW        = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             sync_1, pwm_s, pwm_d, rise;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [DW-1:0]    hi_ext, dividend;
    logic [DW-1:0]    rem_q, div_q;
    logic [6:0]       quo_q, quo_clamped;
    logic [2:0]       iter_q;
    logic             done_q;
    logic             rem_ge, last_iter, capture, timeout;
    logic [1:0]       level_d;
    logic [2:0]       led_d;

    assign rise      = pwm_s & ~pwm_d;
    assign hi_ext    = DW'(hi_cnt);
    assign dividend  = (hi_ext << 6) + (hi_ext << 5) + (hi_ext << 2);
    assign rem_ge    = (rem_q >= div_q);
    assign capture   = rise && (state_q == MEASURE);
    assign last_iter = (state_q == DIVIDE) && (iter_q == 3'd6);
    assign timeout   = (state_q != DIVIDE) && !rise && (per_cnt == TIMEOUT_C);
    assign busy      = (state_q == DIVIDE);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync_1 <= 1'b0;
            pwm_s  <= 1'b0;
            pwm_d  <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            pwm_s  <= sync_1;
            pwm_d  <= pwm_s;
        end
    end

    // The rise cycle itself is the first cycle (and first high cycle) of the new window.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= CNT_ONE;
            hi_cnt  <= CNT_ONE;
        end else begin
            if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_ONE;
            if (pwm_s && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) state_q <= ARM;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (rise) state_d = MEASURE;
            MEASURE: if (rise) state_d = DIVIDE;
                     else if (timeout) state_d = ARM;
            DIVIDE:  if (last_iter) state_d = MEASURE;
            default: state_d = ARM;
        endcase
    end

    // Quotient never exceeds 100, so trial-subtracting per_cap<<6 .. per_cap<<0 suffices.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            iter_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_iter;
            if (capture) begin
                rem_q  <= dividend;
                div_q  <= DW'(per_cnt) << 6;
                quo_q  <= '0;
                iter_q <= '0;
            end else if (state_q == DIVIDE) begin
                if (rem_ge) rem_q <= rem_q - div_q;
                quo_q  <= {quo_q[5:0], rem_ge};
                div_q  <= div_q >> 1;
                iter_q <= iter_q + 3'd1;
            end
        end
    end

    always_comb begin
        quo_clamped = (quo_q > 7'd100) ? 7'd100 : quo_q;
        if (32'(quo_clamped) < TH_LOW)       level_d = 2'b00;
        else if (32'(quo_clamped) < TH_MID)  level_d = 2'b01;
        else if (32'(quo_clamped) < TH_HIGH) level_d = 2'b10;
        else                                 level_d = 2'b11;
        case (level_d)
            2'b00:   led_d = 3'b000;
            2'b01:   led_d = 3'b001;
            2'b10:   led_d = 3'b010;
            default: led_d = 3'b100;
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            duty_pc   <= '0;
            level     <= '0;
            led_level <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
        end else if (done_q) begin
            duty_pc   <= quo_clamped;
            level     <= level_d;
            led_level <= led_d;
            valid     <= 1'b1;
            stuck     <= 1'b0;
        end else if (timeout) begin
            duty_pc   <= pwm_s ? 7'd100 : 7'd0;
            level     <= pwm_s ? 2'b11 : 2'b00;
            led_level <= pwm_s ? 3'b100 : 3'b000;
            valid     <= 1'b1;
            stuck     <= 1'b1;
        end else begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Directed bench for pwm_level_decoder: duty/level results, latency, busy length,
// stuck-line handling, reset during division and back-to-back rises.
module tb_pwm_level_decoder;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       pwm_in = 1'b0;
    logic [6:0] duty_pc;
    logic [1:0] level;
    logic [2:0] led_level;
    logic       valid, busy, stuck;

    int checks = 0;
    int failures = 0;

    int edge_no = 0;
    int rise_ref = 0;
    int vcount, min_lat, max_lat, bcnt, last_busy, last_v_edge, min_gap;
    int min_duty, max_duty;

    pwm_level_decoder #(.TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset_p(reset_p), .pwm_in(pwm_in),
        .duty_pc(duty_pc), .level(level), .led_level(led_level),
        .valid(valid), .busy(busy), .stuck(stuck)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        vcount = 0; min_lat = 1 << 30; max_lat = 0; bcnt = 0; last_busy = -1;
        last_v_edge = -1; min_gap = 1 << 30; min_duty = 127; max_duty = -1;
    endtask

    task automatic tick();
        int lat, gap;
        @(posedge clk);
        #1;
        edge_no++;
        if (busy) bcnt++;
        if (valid) begin
            vcount++;
            lat = edge_no - rise_ref;
            if (lat < min_lat) min_lat = lat;
            if (lat > max_lat) max_lat = lat;
            last_busy = bcnt;
            bcnt = 0;
            if (last_v_edge >= 0) begin
                gap = edge_no - last_v_edge;
                if (gap < min_gap) min_gap = gap;
            end
            last_v_edge = edge_no;
            if (int'(duty_pc) < min_duty) min_duty = int'(duty_pc);
            if (int'(duty_pc) > max_duty) max_duty = int'(duty_pc);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            if (lvl && !pwm_in) rise_ref = edge_no;
            pwm_in = lvl;
            tick();
        end
    endtask

    task automatic run_pwm(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        reset_p = 1'b1;
        tick(); tick(); tick();
        reset_p = 1'b0;
        clear_stats();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (duty_pc !== 7'd0) begin failures++; $display("FAIL reset_duty got=%0d exp=0", duty_pc); end
        checks++; if (level !== 2'b00) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (led_level !== 3'b000) begin failures++; $display("FAIL reset_led got=%b exp=000", led_level); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL reset_stuck got=%b exp=0", stuck); end
    endtask

    task automatic test_duty10();
        do_reset();
        run_pwm(100, 10, 1);
        checks++; if (vcount != 0) begin failures++; $display("FAIL first_rise_valid got=%0d exp=0", vcount); end
        run_pwm(100, 10, 4);
        checks++; if (vcount != 4) begin failures++; $display("FAIL d10_count got=%0d exp=4", vcount); end
        checks++; if (min_lat != 11 || max_lat != 11) begin failures++; $display("FAIL d10_latency got=%0d..%0d exp=11", min_lat, max_lat); end
        checks++; if (duty_pc !== 7'd10) begin failures++; $display("FAIL d10_duty got=%0d exp=10", duty_pc); end
        checks++; if (level !== 2'b01) begin failures++; $display("FAIL d10_level got=%0d exp=1", level); end
        checks++; if (led_level !== 3'b001) begin failures++; $display("FAIL d10_led got=%b exp=001", led_level); end
        checks++; if (last_busy != 7) begin failures++; $display("FAIL d10_busy_len got=%0d exp=7", last_busy); end
    endtask

    task automatic test_levels();
        do_reset();
        run_pwm(100, 20, 2);
        checks++; if (duty_pc !== 7'd20) begin failures++; $display("FAIL d20_duty got=%0d exp=20", duty_pc); end
        checks++; if (level !== 2'b10) begin failures++; $display("FAIL d20_level got=%0d exp=2", level); end
        checks++; if (led_level !== 3'b010) begin failures++; $display("FAIL d20_led got=%b exp=010", led_level); end
        checks++; if (last_busy != 7) begin failures++; $display("FAIL d20_busy_len got=%0d exp=7", last_busy); end
        run_pwm(100, 30, 2);
        checks++; if (duty_pc !== 7'd30) begin failures++; $display("FAIL d30_duty got=%0d exp=30", duty_pc); end
        checks++; if (level !== 2'b11) begin failures++; $display("FAIL d30_level got=%0d exp=3", level); end
        checks++; if (led_level !== 3'b100) begin failures++; $display("FAIL d30_led got=%b exp=100", led_level); end
        checks++; if (last_busy != 7) begin failures++; $display("FAIL d30_busy_len got=%0d exp=7", last_busy); end
    endtask

    task automatic test_truncate_and_idle();
        do_reset();
        run_pwm(300, 47, 3);
        checks++; if (duty_pc !== 7'd15) begin failures++; $display("FAIL trunc_duty got=%0d exp=15", duty_pc); end
        checks++; if (level !== 2'b10) begin failures++; $display("FAIL trunc_level got=%0d exp=2", level); end
        run_pwm(300, 1, 2);
        checks++; if (duty_pc !== 7'd0) begin failures++; $display("FAIL idle_duty got=%0d exp=0", duty_pc); end
        checks++; if (level !== 2'b00) begin failures++; $display("FAIL idle_level got=%0d exp=0", level); end
        checks++; if (led_level !== 3'b000) begin failures++; $display("FAIL idle_led got=%b exp=000", led_level); end
    endtask

    task automatic test_stuck();
        int v0;
        do_reset();
        run_pwm(100, 20, 3);
        v0 = vcount;
        drive(1'b0, 1100);
        checks++; if (vcount != v0 + 1) begin failures++; $display("FAIL stuck_lo_count got=%0d exp=%0d", vcount, v0 + 1); end
        checks++; if (stuck !== 1'b1) begin failures++; $display("FAIL stuck_lo_flag got=%b exp=1", stuck); end
        checks++; if (duty_pc !== 7'd0) begin failures++; $display("FAIL stuck_lo_duty got=%0d exp=0", duty_pc); end
        checks++; if (level !== 2'b00 || led_level !== 3'b000) begin failures++; $display("FAIL stuck_lo_level got=%0d/%b exp=0/000", level, led_level); end
        drive(1'b1, 1100);
        checks++; if (vcount != v0 + 2) begin failures++; $display("FAIL stuck_hi_count got=%0d exp=%0d", vcount, v0 + 2); end
        checks++; if (duty_pc !== 7'd100) begin failures++; $display("FAIL stuck_hi_duty got=%0d exp=100", duty_pc); end
        checks++; if (level !== 2'b11 || led_level !== 3'b100) begin failures++; $display("FAIL stuck_hi_level got=%0d/%b exp=3/100", level, led_level); end
        checks++; if (stuck !== 1'b1) begin failures++; $display("FAIL stuck_hi_flag got=%b exp=1", stuck); end
        drive(1'b0, 50);
        run_pwm(100, 20, 1);
        checks++; if (vcount != v0 + 2 || stuck !== 1'b1) begin failures++; $display("FAIL resume_first got=%0d/%b exp=%0d/1", vcount, stuck, v0 + 2); end
        run_pwm(100, 20, 1);
        checks++; if (vcount != v0 + 3) begin failures++; $display("FAIL resume_count got=%0d exp=%0d", vcount, v0 + 3); end
        checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL resume_stuck got=%b exp=0", stuck); end
        checks++; if (duty_pc !== 7'd20) begin failures++; $display("FAIL resume_duty got=%0d exp=20", duty_pc); end
    endtask

    task automatic test_reset_busy();
        int n;
        do_reset();
        run_pwm(100, 20, 3);
        rise_ref = edge_no;
        pwm_in = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rb_wait_busy got=%b exp=1", busy); end
        reset_p = 1'b1;
        #1;
        checks++; if (duty_pc !== 7'd0 || level !== 2'b00 || led_level !== 3'b000) begin
            failures++; $display("FAIL rb_outputs got=%0d/%0d/%b exp=0/0/000", duty_pc, level, led_level); end
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || stuck !== 1'b0) begin
            failures++; $display("FAIL rb_flags got=%b%b%b exp=000", valid, busy, stuck); end
        pwm_in = 1'b0;
        tick(); tick(); tick();
        reset_p = 1'b0;
        clear_stats();
        drive(1'b0, 30);
        run_pwm(100, 20, 1);
        checks++; if (vcount != 0) begin failures++; $display("FAIL rb_first_rise got=%0d exp=0", vcount); end
        run_pwm(100, 20, 1);
        checks++; if (vcount != 1) begin failures++; $display("FAIL rb_second_rise got=%0d exp=1", vcount); end
        checks++; if (duty_pc !== 7'd20) begin failures++; $display("FAIL rb_duty got=%0d exp=20", duty_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_pwm(6, 3, 30);
        checks++; if (vcount < 10 || vcount > 16) begin failures++; $display("FAIL b2b_count got=%0d exp=10..16", vcount); end
        checks++; if (min_duty != 50 || max_duty != 50) begin failures++; $display("FAIL b2b_duty got=%0d..%0d exp=50", min_duty, max_duty); end
        checks++; if (min_gap < 8) begin failures++; $display("FAIL b2b_gap got=%0d exp>=8", min_gap); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_duty10();
        test_levels();
        test_truncate_and_idle();
        test_stuck();
        test_reset_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_level_decoder.md
Name: pwm_level_decoder

Overview:
- Receiving end of the fan power PWM link: samples a PWM waveform such as `motor_pwm`, measures its high time and period, and computes duty in percent.
- Classifies the measured duty into the fan power levels IDLE/LOW/MID/HIGH and drives the same 3-bit LED encoding the power controller uses.
- Used for closed-loop checking of the motor drive and for level display on boards that only see the PWM line.
- Detects a line stuck low or stuck high.

Parameters:
- CNT_W, 24, width of the period and high-time counters (2,000,000 cycles at 100 MHz / 50 Hz fits).
- TIMEOUT_CYCLES, 4000000, cycles without a rising edge before the line is declared stuck; must be < 2^CNT_W.
- TH_LOW, 1, minimum duty_pc classified LOW.
- TH_MID, 15, minimum duty_pc classified MID.
- TH_HIGH, 25, minimum duty_pc classified HIGH.

Ports:
- clk  input  1  system clock
- reset_p  input  1  asynchronous, active-high reset
- pwm_in  input  1  PWM line, asynchronous to clk
- duty_pc  output  7  measured duty, 0..100 percent
- level  output  2  00 IDLE, 01 LOW, 10 MID, 11 HIGH
- led_level  output  3  IDLE 000, LOW 001, MID 010, HIGH 100
- valid  output  1  one-cycle pulse when duty_pc/level/led_level update
- busy  output  1  high while the divider runs
- stuck  output  1  high while the line is declared stuck

Behaviour:
- Reset (async, reset_p=1): duty_pc=0, level=00, led_level=000, valid=0, busy=0, stuck=0, all counters 0, FSM=ARM. Reset during DIVIDE aborts the division and produces no valid.
- Input synchronisation: pwm_in passes through a 2-flop synchroniser to pwm_s. A rise is pwm_s=1 with the previous pwm_s=0.
- Counters:
  - per_cnt counts clocks since the last rise.
  - hi_cnt counts clocks with pwm_s=1 since the last rise.
  - Both saturate at 2^CNT_W-1.
  - On a rise: per_cap = rise-to-rise distance in clocks; hi_cap = high clocks within that window. Both counters restart, with the rise cycle counted as cycle 1 (hi_cnt counts it as high).
- FSM states: ARM, MEASURE, DIVIDE.
  - ARM: the first rise (after reset or after stuck) only restarts the counters; no capture is taken. Go to MEASURE.
  - MEASURE: a rise latches per_cap/hi_cap and enters DIVIDE; busy=1.
  - DIVIDE: restoring division, dividend = hi_cap*100 (CNT_W+7 bits, shift-add x64+x32+x4), divisor = per_cap.
    - 7 iterations, 1 quotient bit per clock, MSB first, truncating.
    - Quotient clamped to 100.
    - On the clock after the 7th iteration, register duty_pc, level and led_level; pulse valid for 1 cycle; clear busy and stuck; return to MEASURE.
  - Rises during DIVIDE are not captured (the counters still restart). At most one valid per DIVIDE.
- Latency: valid rises 11 clocks after the clk edge that first samples pwm_in=1 (2 sync + 1 capture + 7 divide + 1 output).
- Classification:
  - duty_pc < TH_LOW: IDLE.
  - TH_LOW ≤ duty_pc < TH_MID: LOW.
  - TH_MID ≤ duty_pc < TH_HIGH: MID.
  - duty_pc ≥ TH_HIGH: HIGH.
  - led_level is the fixed function of level listed under Ports.
- Timeout: per_cnt reaching TIMEOUT_CYCLES in ARM or MEASURE:
  - Set stuck=1 and pulse valid once.
  - pwm_s=0: duty_pc=0, level=IDLE, led_level=000. pwm_s=1: duty_pc=100, level=HIGH, led_level=100.
  - Go to ARM; no further valid until two rises have occurred.
- stuck stays 1 until the next completed division.
- Divisor zero is impossible (per_cap ≥ 1 by construction); hi_cap ≤ per_cap always.
- Outputs hold their last values between valid pulses.

Test Plan:
- Period 100, high 10, TIMEOUT_CYCLES=1000 -> no valid on the first rise; on each later rise, valid exactly 11 clocks after pwm_in rise with duty_pc=10, level=01, led_level=001.
- Period 100, high 20, then high 30 -> duty_pc=20/level=10/led=010, then duty_pc=30/level=11/led=100; busy high exactly 7 cycles per measurement.
- Period 300, high 47 -> duty_pc=15 (truncated from 15.67), level=10. Period 300, high 0 for one period between rises (pulses of 1 clock) -> duty_pc=0, level=00.
- pwm_in held low 1000+ cycles -> stuck=1, single valid, duty_pc=0, level=00. Held high -> duty_pc=100, level=11, led=100. Then resume period 100/high 20 -> stuck clears on the second rise's result, duty_pc=20.
- reset_p pulsed while busy=1 -> all outputs 0 immediately, no valid; the next valid needs two rises.
- Period 6, high 3 -> rises during DIVIDE ignored, valid at most once per 8 clocks, every reported duty_pc=50.
